// File: rtl/clint_timer_slave_if.sv
// Request/ready bus between the CPU and the CLINT timer slave.
// The master drives the request fields; the slave returns rdata and a one-cycle ready.
interface clint_timer_slave_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;

    modport master (output req, we, addr, wdata, wstrb, input rdata, ready);
    modport slave  (input req, we, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/clint_timer_slave.sv
// CLINT-style machine timer (mtime, mtimecmp, msip) behind a req/ready slave bus.
// Optional: define CLINT_MTIME_SNAPSHOT_EN for a tear-free lo-then-hi mtime read via a shadow register.
module clint_timer_slave #(
    parameter int unsigned TICK_DIV     = 1,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    clint_timer_slave_if.slave bus,
    output logic               timer_irq,
    output logic               soft_irq
);
    typedef enum logic {IDLE, ACK} state_t;

    state_t      state;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;
    logic [15:0] prescaler;
    logic [31:0] rd_val;
    logic [31:0] hi_view;
    logic        access;
    logic        wr;
    logic        tick;
    logic        sel_msip;
    logic        sel_cmp_lo;
    logic        sel_cmp_hi;
    logic        sel_time_lo;
    logic        sel_time_hi;
    logic        unused_addr;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                                input logic [31:0] wd,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? wd[8*b +: 8] : old[8*b +: 8];
        end
        return res;
    endfunction

    assign access      = (state == IDLE) && bus.req;
    assign wr          = access && bus.we;
    assign tick        = (prescaler == 16'(TICK_DIV - 1));
    assign sel_msip    = (bus.addr[15:2] == 14'h0000);
    assign sel_cmp_lo  = (bus.addr[15:2] == 14'h1000);
    assign sel_cmp_hi  = (bus.addr[15:2] == 14'h1001);
    assign sel_time_lo = (bus.addr[15:2] == 14'h2FFE);
    assign sel_time_hi = (bus.addr[15:2] == 14'h2FFF);
    // The region decode happens upstream; these address bits are intentionally ignored.
    assign unused_addr = ^{bus.addr[31:16], bus.addr[1:0]};

`ifdef CLINT_MTIME_SNAPSHOT_EN
    logic [31:0] shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (access && !bus.we && sel_time_lo) begin
            shadow <= mtime[63:32];
        end
    end

    assign hi_view = shadow;
`else
    assign hi_view = mtime[63:32];
`endif

    always_comb begin
        rd_val = '0;
        if (sel_msip)    rd_val = {31'b0, msip};
        if (sel_cmp_lo)  rd_val = mtimecmp[31:0];
        if (sel_cmp_hi)  rd_val = mtimecmp[63:32];
        if (sel_time_lo) rd_val = mtime[31:0];
        if (sel_time_hi) rd_val = hi_view;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            mtime     <= '0;
            mtimecmp  <= MTIMECMP_RST;
            msip      <= 1'b0;
            timer_irq <= 1'b0;
            soft_irq  <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 16'd1;
            // A bus write to either mtime half wins over the tick and drops that increment.
            if (wr && sel_time_lo) begin
                mtime[31:0] <= merge_lanes(mtime[31:0], bus.wdata, bus.wstrb);
            end else if (wr && sel_time_hi) begin
                mtime[63:32] <= merge_lanes(mtime[63:32], bus.wdata, bus.wstrb);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
            if (wr && sel_cmp_lo) mtimecmp[31:0]  <= merge_lanes(mtimecmp[31:0], bus.wdata, bus.wstrb);
            if (wr && sel_cmp_hi) mtimecmp[63:32] <= merge_lanes(mtimecmp[63:32], bus.wdata, bus.wstrb);
            if (wr && sel_msip && bus.wstrb[0]) msip <= bus.wdata[0];
            timer_irq <= (mtime >= mtimecmp);
            soft_irq  <= msip;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bus.ready <= 1'b0;
            bus.rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        state     <= ACK;
                        bus.ready <= 1'b1;
                        bus.rdata <= rd_val;
                    end
                end
                ACK: begin
                    state     <= IDLE;
                    bus.ready <= 1'b0;
                    bus.rdata <= '0;
                end
                default: begin
                    state     <= IDLE;
                    bus.ready <= 1'b0;
                    bus.rdata <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_clint_timer_slave.sv
// Drives two timer instances (TICK_DIV=4 and TICK_DIV=1) from one bus stimulus
// and checks every cycle against a behavioural register-level model.
module tb_clint_timer_slave;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        tirq4, sirq4, tirq1, sirq1;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    clint_timer_slave_if bus4 ();
    clint_timer_slave_if bus1 ();

    assign bus4.req = d_req;  assign bus1.req = d_req;
    assign bus4.we = d_we;    assign bus1.we = d_we;
    assign bus4.addr = d_addr;   assign bus1.addr = d_addr;
    assign bus4.wdata = d_wdata; assign bus1.wdata = d_wdata;
    assign bus4.wstrb = d_wstrb; assign bus1.wstrb = d_wstrb;

    clint_timer_slave #(.TICK_DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave),
                                            .timer_irq(tirq4), .soft_irq(sirq4));
    clint_timer_slave #(.TICK_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave),
                                            .timer_irq(tirq1), .soft_irq(sirq1));

    // Reference model: index 0 is the divide-by-4 timer, index 1 the divide-by-1 timer.
    logic [63:0]     m_mtime [2];
    logic [31:0]     m_shadow [2];
    logic [63:0]     m_cmp;
    logic            m_msip;
    logic            m_took;
    longint unsigned m_edges;
    logic [31:0]     e_rdata [2];
    logic            e_tirq [2];
    logic            e_ready, e_wack, e_sirq;
    logic            m_take;
    logic [15:0]     m_off;

    // The slave accepts a held request only every other cycle.
    assign m_take = d_req && !m_took;
    assign m_off  = {d_addr[15:2], 2'b00};

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
        logic [31:0] mask;
        mask = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
        return (old & ~mask) | (wd & mask);
    endfunction

    function automatic logic [31:0] m_read(input int i);
        case (m_off)
            16'h0000: return {31'b0, m_msip};
            16'h4000: return m_cmp[31:0];
            16'h4004: return m_cmp[63:32];
            16'hBFF8: return m_mtime[i][31:0];
`ifdef CLINT_MTIME_SNAPSHOT_EN
            16'hBFFC: return m_shadow[i];
`else
            16'hBFFC: return m_mtime[i][63:32];
`endif
            default:  return 32'h0;
        endcase
    endfunction

    function automatic logic [63:0] m_next_mtime(input int i);
        if (m_take && d_we && m_off == 16'hBFF8)
            return {m_mtime[i][63:32], lanes(m_mtime[i][31:0], d_wdata, d_wstrb)};
        if (m_take && d_we && m_off == 16'hBFFC)
            return {lanes(m_mtime[i][63:32], d_wdata, d_wstrb), m_mtime[i][31:0]};
        if ((m_edges % longint'(div_of(i))) == longint'(div_of(i) - 1))
            return m_mtime[i] + 64'd1;
        return m_mtime[i];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cmp   <= 64'hFFFF_FFFF_FFFF_FFFF;
            m_msip  <= 1'b0;
            m_took  <= 1'b0;
            m_edges <= 0;
            e_ready <= 1'b0;
            e_wack  <= 1'b0;
            e_sirq  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_mtime[i]  <= '0;
                m_shadow[i] <= '0;
                e_rdata[i]  <= '0;
                e_tirq[i]   <= 1'b0;
            end
        end else begin
            m_took  <= m_take;
            m_edges <= m_edges + 1;
            e_ready <= m_take;
            e_wack  <= m_take && d_we;
            e_sirq  <= m_msip;
            for (int i = 0; i < 2; i++) begin
                e_rdata[i] <= m_take ? m_read(i) : 32'h0;
                e_tirq[i]  <= (m_mtime[i] >= m_cmp);
                m_mtime[i] <= m_next_mtime(i);
                if (m_take && !d_we && m_off == 16'hBFF8) m_shadow[i] <= m_mtime[i][63:32];
            end
            if (m_take && d_we && m_off == 16'h0000 && d_wstrb[0]) m_msip <= d_wdata[0];
            if (m_take && d_we && m_off == 16'h4000) m_cmp[31:0]  <= lanes(m_cmp[31:0], d_wdata, d_wstrb);
            if (m_take && d_we && m_off == 16'h4004) m_cmp[63:32] <= lanes(m_cmp[63:32], d_wdata, d_wstrb);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("ready4", 64'(bus4.ready), 64'(e_ready));
        chk("ready1", 64'(bus1.ready), 64'(e_ready));
        if (!e_wack) begin
            chk("rdata4", 64'(bus4.rdata), 64'(e_rdata[0]));
            chk("rdata1", 64'(bus1.rdata), 64'(e_rdata[1]));
        end
        chk("timer_irq4", 64'(tirq4), 64'(e_tirq[0]));
        chk("timer_irq1", 64'(tirq1), 64'(e_tirq[1]));
        chk("soft_irq4", 64'(sirq4), 64'(e_sirq));
        chk("soft_irq1", 64'(sirq1), 64'(e_sirq));
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, output logic [31:0] rd4, output logic [31:0] rd1);
        d_req = 1'b1; d_we = w; d_addr = a; d_wdata = wd; d_wstrb = st;
        step();
        rd4 = bus4.rdata;
        rd1 = bus1.rdata;
        d_req = 1'b0;
        step();
    endtask

    initial begin
        logic [31:0] rd4, rd1, acc_rd;
        logic [5:0]  pat;
        logic [31:0] offs [5];
        offs = '{32'h0000, 32'h4000, 32'h4004, 32'hBFF8, 32'hBFFC};

        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(bus4.ready | bus1.ready), 64'h0);
        chk("rst_rdata", 64'(bus4.rdata | bus1.rdata), 64'h0);
        chk("rst_irqs", 64'({tirq4, sirq4, tirq1, sirq1}), 64'h0);
        rst_n = 1'b1;

        // Idle count-up with TICK_DIV=4.
        repeat (40) step();
        access(1'b0, 32'h0200_BFF8, 32'h0, 4'h0, rd4, rd1);
        chk("t1_mtime_div4_near_10", 64'(rd4 >= 32'd9 && rd4 <= 32'd11), 64'h1);
        chk("t1_timer_irq_low", 64'(tirq4 | tirq1), 64'h0);

        // Compare match, then move the compare out of reach.
        access(1'b1, 32'h0200_4000, 32'd100, 4'hF, rd4, rd1);
        access(1'b1, 32'h0200_4004, 32'd0, 4'hF, rd4, rd1);
        for (int k = 0; k < 300 && !tirq1; k++) step();
        chk("t2_irq_rise_div1", 64'(tirq1), 64'h1);
        access(1'b1, 32'h0200_4004, 32'd1, 4'hF, rd4, rd1);
        step(); step();
        chk("t2_irq_fall", 64'(tirq1 | tirq4), 64'h0);

        // Software interrupt.
        access(1'b1, 32'h0200_0000, 32'hFFFF_FFFF, 4'hF, rd4, rd1);
        step();
        chk("t3_soft_irq_set", 64'(sirq1 & sirq4), 64'h1);
        access(1'b0, 32'h0200_0000, 32'h0, 4'h0, rd4, rd1);
        chk("t3_msip_read", 64'(rd1), 64'h1);
        access(1'b1, 32'h0200_0000, 32'h0, 4'hF, rd4, rd1);
        step();
        chk("t3_soft_irq_clr", 64'(sirq1 | sirq4), 64'h0);

        // 64-bit wrap and byte-lane write.
        access(1'b1, 32'h0200_BFFC, 32'hFFFF_FFFF, 4'hF, rd4, rd1);
        access(1'b1, 32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF, rd4, rd1);
        access(1'b0, 32'h0200_BFFC, 32'h0, 4'h0, rd4, rd1);
        chk("t4_wrap_hi", 64'(rd1), 64'h0);
        access(1'b0, 32'h0200_BFF8, 32'h0, 4'h0, rd4, rd1);
        chk("t4_wrap_lo_small", 64'(rd1 < 32'd16), 64'h1);
        access(1'b1, 32'h0200_BFF8, 32'h0000_00AB, 4'b0001, rd4, rd1);
        access(1'b0, 32'h0200_BFF8, 32'h0, 4'h0, rd4, rd1);
        chk("t4_byte0_write", 64'(rd1[7:0]), 64'hAC);

        // Held request to an unmapped offset.
        pat = '0; acc_rd = '0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0200_1234;
        for (int k = 0; k < 6; k++) begin
            step();
            pat[k] = bus1.ready;
            acc_rd = acc_rd | bus1.rdata | bus4.rdata;
        end
        d_req = 1'b0;
        chk("t5_ready_pattern", 64'(pat), 64'h15);
        chk("t5_rdata_zero", 64'(acc_rd), 64'h0);

        // Lo-then-hi read across a carry.
        access(1'b1, 32'h0200_BFFC, 32'h0, 4'hF, rd4, rd1);
        access(1'b1, 32'h0200_BFF8, 32'hFFFF_FFFE, 4'hF, rd4, rd1);
        access(1'b0, 32'h0200_BFF8, 32'h0, 4'h0, rd4, rd1);
        chk("t6_lo", 64'(rd1), 64'hFFFF_FFFF);
        access(1'b0, 32'h0200_BFFC, 32'h0, 4'h0, rd4, rd1);
`ifdef CLINT_MTIME_SNAPSHOT_EN
        chk("t6_hi_snapshot", 64'(rd1), 64'h0);
`else
        chk("t6_hi_live", 64'(rd1), 64'h1);
`endif

        // Randomised accesses, checked cycle by cycle against the model.
        for (int k = 0; k < 120; k++) begin
            logic [31:0] a;
            a = {16'h0200, offs[$urandom_range(0, 4)][15:2], 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 5) == 0) a = $urandom();
            access(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)), rd4, rd1);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
